ct_pt_mul_sequencer: RTL

- Micro-sequencer that runs one ciphertext-plaintext multiply on the cpu's shared functional-unit pair.
- The multiply is ten micro-ops: twist, NTT, pointwise MUL, inverse NTT and untwist, first for the CT.A half, then for the CT.B half.
- The cpu controller starts it on an OP_CT_PT_MUL instruction. It drives the FU mux selects, fu start/done handshake, regfile writeback strobes and the instruction-done pulse, so the cpu does not need a free-running stage counter.

---
 rtl/ct_pt_mul_sequencer_pkg.sv | 32 +++
 rtl/ct_pt_mul_sequencer_timeout_ctr.sv | 39 +++
 rtl/ct_pt_mul_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ct_pt_mul_sequencer_pkg.sv
// Shared types and constants for the ciphertext-plaintext multiply sequencer.
package ct_pt_mul_sequencer_pkg;

    localparam int REG_NPOLY       = 32;
    localparam int REG_IDX_W       = $clog2(REG_NPOLY);
    localparam int CTPT_STEPS      = 10;
    localparam int CTPT_SPLIT_STEP = 4;

    typedef enum logic [2:0] {
        UOP_TWIST   = 3'd0,
        UOP_NTT     = 3'd1,
        UOP_MUL     = 3'd2,
        UOP_INTT    = 3'd3,
        UOP_UNTWIST = 3'd4
    } uop_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Both halves run the same five-op pipeline, so the op is k folded onto 0..4.
    function automatic uop_e uop_of_step(input logic [3:0] k);
        logic [3:0] m;
        m = (k > 4'(CTPT_SPLIT_STEP)) ? (k - 4'(CTPT_SPLIT_STEP + 1)) : k;
        return uop_e'(m[2:0]);
    endfunction

endpackage

// File: rtl/ct_pt_mul_sequencer_timeout_ctr.sv
// Loadable down-counter guarding the wait for fu_done; expired when it hits zero.
module ctpt_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = CNT_W'(TIMEOUT_CYC - 1);
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/ct_pt_mul_sequencer.sv
// Ten-step twist/NTT/MUL/INTT/untwist sequencer for one CT-PT multiply on the shared FU pair.
module ct_pt_mul_sequencer
    import ct_pt_mul_sequencer_pkg::*;
#(
    parameter int REG_IDX_W   = ct_pt_mul_sequencer_pkg::REG_IDX_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [REG_IDX_W-1:0] dest0_idx,
    input  logic [REG_IDX_W-1:0] dest1_idx,
    input  logic                 fu_done,
    output logic                 busy,
    output logic                 uop_valid,
    output logic [2:0]           uop,
    output logic                 uop_half,
    output logic                 uop_inverse,
    output logic                 wb0_valid,
    output logic                 wb1_valid,
    output logic [REG_IDX_W-1:0] wb_idx,
    output logic                 done,
    output logic                 timeout_err,
    output logic [2:0]           dbg_state
);

    localparam logic [3:0] K_SPLIT = 4'(CTPT_SPLIT_STEP);
    localparam logic [3:0] K_B0    = 4'(CTPT_SPLIT_STEP + 1);
    localparam logic [3:0] K_LAST  = 4'(CTPT_STEPS - 1);

    state_e               state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic                 abort_q, abort_d;
    logic [REG_IDX_W-1:0] dest0_q, dest1_q;
    logic                 to_load, to_clear, to_en, to_expired;
    logic                 accept;
    logic                 active_d;
    uop_e                 uop_d;

    logic                 busy_q, uop_valid_q, uop_half_q, uop_inverse_q;
    logic                 wb0_q, wb1_q, done_q, timeout_err_q;
    logic [2:0]           uop_q;
    logic [REG_IDX_W-1:0] wb_idx_q;

    ctpt_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .load_i    (to_load),
        .clear_i   (to_clear),
        .en_i      (to_en),
        .expired_o (to_expired)
    );

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        abort_d  = abort_q;
        to_load  = 1'b0;
        to_clear = 1'b0;
        to_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    abort_d = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                to_load = 1'b1;
            end
            S_WAIT: begin
                // fu_done on the limit cycle still counts as a completed step.
                if (fu_done) begin
                    to_clear = 1'b1;
                    if (k_q == K_SPLIT) begin
                        state_d = S_WB;
                    end else if (k_q == K_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (to_expired) begin
                    to_clear = 1'b1;
                    abort_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    to_en = 1'b1;
                end
            end
            S_WB: begin
                k_d     = K_B0;
                state_d = S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign active_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    assign uop_d    = uop_of_step(k_d);

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            abort_q       <= 1'b0;
            dest0_q       <= '0;
            dest1_q       <= '0;
            busy_q        <= 1'b0;
            uop_valid_q   <= 1'b0;
            uop_q         <= '0;
            uop_half_q    <= 1'b0;
            uop_inverse_q <= 1'b0;
            wb0_q         <= 1'b0;
            wb1_q         <= 1'b0;
            wb_idx_q      <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            abort_q       <= abort_d;
            if (accept) begin
                dest0_q <= dest0_idx;
                dest1_q <= dest1_idx;
            end
            busy_q        <= (state_d != S_IDLE);
            uop_valid_q   <= (state_d == S_ISSUE);
            uop_q         <= active_d ? uop_d : UOP_TWIST;
            uop_half_q    <= active_d && (k_d >= K_B0);
            uop_inverse_q <= active_d && (uop_d == UOP_INTT);
            wb0_q         <= (state_d == S_WB);
            wb1_q         <= (state_d == S_DONE) && !abort_d;
            if (state_d == S_WB) begin
                wb_idx_q <= dest0_q;
            end else if ((state_d == S_DONE) && !abort_d) begin
                wb_idx_q <= dest1_q;
            end else begin
                wb_idx_q <= '0;
            end
            done_q        <= (state_d == S_DONE);
            if (accept) begin
                timeout_err_q <= 1'b0;
            end else if ((state_q == S_WAIT) && (state_d == S_DONE) && abort_d) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign busy        = busy_q;
    assign uop_valid   = uop_valid_q;
    assign uop         = uop_q;
    assign uop_half    = uop_half_q;
    assign uop_inverse = uop_inverse_q;
    assign wb0_valid   = wb0_q;
    assign wb1_valid   = wb1_q;
    assign wb_idx      = wb_idx_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule
